// File: rtl/lc3bp_dmem_wait_model_pkg.sv
// Shared definitions for the LC3BP D-cache memory model: FSM encodings, lane width, LFSR constants, counter helper.
// LFSR constants exist only when DMEM_RAND_WAIT_EN is defined.
package lc3bp_mem_pkg;

    localparam int LANE_W = 8;
    localparam int SAT_W  = 64;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_WAIT = 2'd1;
    localparam fsm_state_t ST_RESP = 2'd2;

`ifdef DMEM_RAND_WAIT_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois form of x^16 + x^14 + x^13 + x^11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
`endif

    // Increment v, holding at the all-ones value of a w-bit counter (w <= 64).
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v, input int w);
        logic [SAT_W-1:0] lim;
        lim = (w >= SAT_W) ? {SAT_W{1'b1}} : ((64'd1 << w) - 64'd1);
        return (v >= lim) ? lim : (v + 64'd1);
    endfunction

endpackage

// File: rtl/lc3bp_dmem_wait_model_if.sv
// D-cache request/response bundle between the LC3BP core (master) and the memory model (slave).
interface lc3bp_dmem_wait_model_if
    import lc3bp_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) ();
    localparam int LANES = DATA_W / LANE_W;

    logic              dcache_en;
    logic [LANES-1:0]  dcache_we;
    logic [ADDR_W-1:0] dcache_addr;
    logic [DATA_W-1:0] dcache_din;
    logic              dcache_r;
    logic [DATA_W-1:0] dcache_dout;

    modport master (
        output dcache_en, dcache_we, dcache_addr, dcache_din,
        input  dcache_r, dcache_dout
    );

    modport slave (
        input  dcache_en, dcache_we, dcache_addr, dcache_din,
        output dcache_r, dcache_dout
    );
endinterface

// File: rtl/lc3bp_dmem_wait_model_lfsr16.sv
// 16-bit Galois LFSR that advances once per step pulse; only built when DMEM_RAND_WAIT_EN is defined.
`ifdef DMEM_RAND_WAIT_EN
module lc3bp_lfsr16
    import lc3bp_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] value
);
    logic [15:0] r_value;

    // Shift right, folding the taps in when a one falls out of bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= LFSR_SEED;
        end else if (step) begin
            r_value <= {1'b0, r_value[15:1]} ^ (r_value[0] ? LFSR_TAPS : 16'h0000);
        end else begin
            r_value <= r_value;
        end
    end

    assign value = r_value;
endmodule
`endif

// File: rtl/lc3bp_dmem_wait_model.sv
// LC3BP D-cache data-memory model: programmable wait states, byte-lane writes, abort handling, statistics.
// Optional: DMEM_RAND_WAIT_EN draws each request's wait from a 16-bit LFSR instead of the fixed WAIT_CYCLES.
module lc3bp_dmem_wait_model
    import lc3bp_mem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 32768,
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    lc3bp_dmem_wait_model_if.slave bus,
    output logic [CNT_W-1:0]       access_cnt,
    output logic [CNT_W-1:0]       stall_cnt
);
    localparam int LANES = DATA_W / LANE_W;
    localparam int OFF_W = $clog2(LANES);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
`ifdef DMEM_RAND_WAIT_EN
    localparam bit USE_FSM = 1'b1;
`else
    localparam bit USE_FSM = (WAIT_CYCLES != 0);
`endif

    // Not reset: contents survive rst and are preloaded hierarchically by benches.
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic [ADDR_W-1:0] w_addr;
    logic [IDX_W-1:0]  w_req_idx;
    logic [IDX_W-1:0]  w_idx;
    logic [LANES-1:0]  w_we;
    logic [DATA_W-1:0] w_din;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_in_resp;
    logic              w_ack;
    logic [CNT_W-1:0]  r_access_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_addr    = bus.dcache_addr;
    assign w_req_idx = IDX_W'(w_addr >> OFF_W);
    assign w_ack     = bus.dcache_en && w_in_resp && !rst;
    assign w_rd_word = mem[w_idx];

    if (USE_FSM) begin : g_fsm
        fsm_state_t        r_state;
        logic [3:0]        r_cnt;
        logic [IDX_W-1:0]  r_idx;
        logic [LANES-1:0]  r_we;
        logic [DATA_W-1:0] r_din;
        logic [3:0]        w_wait_len;

`ifdef DMEM_RAND_WAIT_EN
        logic [15:0] w_lfsr;
        logic [15:0] w_draw;
        logic        w_capture;

        assign w_capture = (r_state == ST_IDLE) && bus.dcache_en;
        lc3bp_lfsr16 u_lfsr (
            .clk   (clk),
            .rst   (rst),
            .step  (w_capture),
            .value (w_lfsr)
        );
        assign w_draw = w_lfsr % 16'(WAIT_CYCLES + 1);
        // A zero draw still costs one cycle: this build never acks combinationally.
        assign w_wait_len = (w_draw == 16'd0) ? 4'd1 : w_draw[3:0];
`else
        assign w_wait_len = 4'(WAIT_CYCLES);
`endif

        // Request sequencer: capture in IDLE, count wait states, ack once in RESP; en low aborts.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_cnt   <= 4'd0;
                r_idx   <= {IDX_W{1'b0}};
                r_we    <= {LANES{1'b0}};
                r_din   <= {DATA_W{1'b0}};
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.dcache_en) begin
                            r_idx   <= w_req_idx;
                            r_we    <= bus.dcache_we;
                            r_din   <= bus.dcache_din;
                            r_cnt   <= w_wait_len - 4'd1;
                            r_state <= (w_wait_len == 4'd1) ? ST_RESP : ST_WAIT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_WAIT: begin
                        if (!bus.dcache_en) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt   <= r_cnt - 4'd1;
                            r_state <= (r_cnt == 4'd1) ? ST_RESP : ST_WAIT;
                        end
                    end
                    ST_RESP: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end

        assign w_idx     = r_idx;
        assign w_we      = r_we;
        assign w_din     = r_din;
        assign w_in_resp = (r_state == ST_RESP);
    end else begin : g_comb
        assign w_idx     = w_req_idx;
        assign w_we      = bus.dcache_we;
        assign w_din     = bus.dcache_din;
        assign w_in_resp = 1'b1;
    end

    // Commit the enabled byte lanes at the edge that ends the acknowledged cycle.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (w_ack && w_we[l]) begin
                mem[w_idx][l*LANE_W +: LANE_W] <= w_din[l*LANE_W +: LANE_W];
            end
        end
    end

    // Read data is visible only while acking; the wait-state path returns zero for writes.
    always_comb begin
        bus.dcache_dout = {DATA_W{1'b0}};
        if (w_ack && (!USE_FSM || (w_we == {LANES{1'b0}}))) begin
            bus.dcache_dout = w_rd_word;
        end else begin
            bus.dcache_dout = {DATA_W{1'b0}};
        end
    end

    assign bus.dcache_r = w_ack;

    // Saturating statistics: completed accesses and requested-but-not-acked cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_access_cnt <= {CNT_W{1'b0}};
            r_stall_cnt  <= {CNT_W{1'b0}};
        end else begin
            if (w_ack) begin
                r_access_cnt <= CNT_W'(sat_inc(SAT_W'(r_access_cnt), CNT_W));
            end else begin
                r_access_cnt <= r_access_cnt;
            end
            if (bus.dcache_en && !w_ack) begin
                r_stall_cnt <= CNT_W'(sat_inc(SAT_W'(r_stall_cnt), CNT_W));
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end
    end

    assign access_cnt = r_access_cnt;
    assign stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_lc3bp_dmem_wait_model.sv
// Scoreboard bench for lc3bp_dmem_wait_model: a zero-wait instance and a 3-wait-state instance side by side.
module tb_lc3bp_dmem_wait_model;

    typedef struct packed {
        logic        chk;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic rst0;
    logic rst3;
    logic [31:0] acc_cnt0, stall_cnt0, acc_cnt3, stall_cnt3;

    int n_cmp = 0;
    int n_err = 0;
    int exp_acc3 = 0;
    int exp_stall3 = 0;
    exp_t q0[$];
    exp_t q3[$];

    lc3bp_dmem_wait_model_if #(.DATA_W(16), .ADDR_W(16)) if0 ();
    lc3bp_dmem_wait_model_if #(.DATA_W(16), .ADDR_W(16)) if3 ();

    lc3bp_dmem_wait_model #(.DATA_W(16), .ADDR_W(16), .DEPTH_WORDS(32768), .WAIT_CYCLES(0), .CNT_W(32)) u_dut0 (
        .clk        (clk),
        .rst        (rst0),
        .bus        (if0),
        .access_cnt (acc_cnt0),
        .stall_cnt  (stall_cnt0)
    );

    lc3bp_dmem_wait_model #(.DATA_W(16), .ADDR_W(16), .DEPTH_WORDS(1024), .WAIT_CYCLES(3), .CNT_W(32)) u_dut3 (
        .clk        (clk),
        .rst        (rst3),
        .bus        (if3),
        .access_cnt (acc_cnt3),
        .stall_cnt  (stall_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitors: pop the expected response whenever a DUT acks.
    always @(negedge clk) begin
        if (if0.dcache_r === 1'b1) begin
            if (q0.size() == 0) begin
                check("sb0_unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                if (e.chk) check("sb0_dout", 32'(if0.dcache_dout), 32'(e.data));
            end
        end
    end

    always @(negedge clk) begin
        if (if3.dcache_r === 1'b1) begin
            if (q3.size() == 0) begin
                check("sb3_unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                if (e.chk) check("sb3_dout", 32'(if3.dcache_dout), 32'(e.data));
            end
        end
    end

    // Zero-wait access: ack in the same cycle, en stays up for back-to-back issue.
    task automatic acc0(input logic [15:0] a, input logic [1:0] we, input logic [15:0] d,
                        input logic chk, input logic [15:0] exp);
        q0.push_back({chk, exp});
        if0.dcache_en   = 1'b1;
        if0.dcache_we   = we;
        if0.dcache_addr = a;
        if0.dcache_din  = d;
        #1;
        check("w0_ack_same_cycle", 32'(if0.dcache_r), 32'd1);
        @(posedge clk); #1;
    endtask

    // Three-wait access: scrambles the bus after capture, checks latency, holds en through the ack edge.
    task automatic acc3(input logic [15:0] a, input logic [1:0] we, input logic [15:0] d,
                        input logic [15:0] exp, input string nm);
        int lat;
        q3.push_back({1'b1, (we == 2'b00) ? exp : 16'h0000});
        if3.dcache_en   = 1'b1;
        if3.dcache_we   = we;
        if3.dcache_addr = a;
        if3.dcache_din  = d;
        @(posedge clk); #1;
        lat = 1;
        if3.dcache_addr = 16'h0010;
        if3.dcache_we   = 2'b11;
        if3.dcache_din  = 16'hFFFF;
        while (if3.dcache_r !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'd3);
        @(posedge clk); #1;
        if3.dcache_en = 1'b0;
        if3.dcache_we = 2'b00;
        exp_acc3++;
        exp_stall3 += 3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        rst0 = 1'b1;
        rst3 = 1'b1;
        if0.dcache_en = 1'b1; if0.dcache_we = 2'b00; if0.dcache_addr = 16'h0000; if0.dcache_din = 16'h0000;
        if3.dcache_en = 1'b1; if3.dcache_we = 2'b00; if3.dcache_addr = 16'h0010; if3.dcache_din = 16'h0000;
        u_dut0.mem[1] = 16'h1234;
        u_dut3.mem[8] = 16'hBEEF;
        u_dut3.mem[9] = 16'h1234;
        #2;
        check("rst_r0", 32'(if0.dcache_r), 32'd0);
        check("rst_dout0", 32'(if0.dcache_dout), 32'd0);
        check("rst_acc0", acc_cnt0, 32'd0);
        check("rst_stall0", stall_cnt0, 32'd0);
        check("rst_r3", 32'(if3.dcache_r), 32'd0);
        check("rst_acc3", acc_cnt3, 32'd0);
        check("rst_stall3", stall_cnt3, 32'd0);
        if0.dcache_en = 1'b0;
        if3.dcache_en = 1'b0;
        #20;
        rst0 = 1'b0;
        rst3 = 1'b0;
        @(posedge clk); #1;

        // Zero-wait instance: full write, readback, byte lanes, low address bit ignored.
        acc0(16'h0000, 2'b11, 16'h0005, 1'b0, 16'h0000);
        acc0(16'h0000, 2'b00, 16'h0000, 1'b1, 16'h0005);
        acc0(16'h0002, 2'b01, 16'hABCD, 1'b0, 16'h0000);
        acc0(16'h0003, 2'b00, 16'h0000, 1'b1, 16'h12CD);
        acc0(16'h0002, 2'b10, 16'hABCD, 1'b0, 16'h0000);
        acc0(16'h0002, 2'b00, 16'h0000, 1'b1, 16'hABCD);
        if0.dcache_en = 1'b0;
        if0.dcache_we = 2'b00;
        #1;
        check("w0_idle_r", 32'(if0.dcache_r), 32'd0);
        check("w0_idle_dout", 32'(if0.dcache_dout), 32'd0);
        check("w0_access_cnt", acc_cnt0, 32'd6);
        check("w0_stall_cnt", stall_cnt0, 32'd0);

        // Three-wait instance.
        acc3(16'h0010, 2'b00, 16'h0000, 16'hBEEF, "w3_read");
        check("w3_first_stall", stall_cnt3, 32'd3);
        check("w3_first_acc", acc_cnt3, 32'd1);
        acc3(16'h0810, 2'b00, 16'h0000, 16'hBEEF, "w3_wrap");
        acc3(16'h0012, 2'b01, 16'hABCD, 16'h0000, "w3_wr_lo");
        acc3(16'h0013, 2'b00, 16'h0000, 16'h12CD, "w3_rd_lo");
        acc3(16'h0012, 2'b10, 16'hABCD, 16'h0000, "w3_wr_hi");
        acc3(16'h0012, 2'b00, 16'h0000, 16'hABCD, "w3_rd_hi");

        // Abort during WAIT after two request cycles.
        if3.dcache_en = 1'b1; if3.dcache_we = 2'b11; if3.dcache_addr = 16'h0010; if3.dcache_din = 16'h5555;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("w3_abort_wait_r", 32'(if3.dcache_r), 32'd0);
        if3.dcache_en = 1'b0; if3.dcache_we = 2'b00;
        exp_stall3 += 2;
        @(posedge clk); #1;
        check("w3_abort_wait_acc", acc_cnt3, 32'(exp_acc3));
        acc3(16'h0010, 2'b00, 16'h0000, 16'hBEEF, "w3_after_abort_wait");

        // Abort in RESP: the ack is withdrawn and the write is dropped.
        if3.dcache_en = 1'b1; if3.dcache_we = 2'b11; if3.dcache_addr = 16'h0010; if3.dcache_din = 16'h5555;
        repeat (3) begin @(posedge clk); #1; end
        check("w3_resp_r_before_drop", 32'(if3.dcache_r), 32'd1);
        if3.dcache_en = 1'b0; if3.dcache_we = 2'b00;
        #1;
        check("w3_abort_resp_r", 32'(if3.dcache_r), 32'd0);
        check("w3_abort_resp_dout", 32'(if3.dcache_dout), 32'd0);
        exp_stall3 += 3;
        @(posedge clk); #1;
        check("w3_abort_resp_acc", acc_cnt3, 32'(exp_acc3));
        acc3(16'h0010, 2'b00, 16'h0000, 16'hBEEF, "w3_after_abort_resp");
        check("w3_access_total", acc_cnt3, 32'(exp_acc3));
        check("w3_stall_total", stall_cnt3, 32'(exp_stall3));

        // Asynchronous reset in the middle of a WAIT.
        if3.dcache_en = 1'b1; if3.dcache_we = 2'b00; if3.dcache_addr = 16'h0012;
        @(posedge clk); #1;
        rst3 = 1'b1;
        #1;
        check("w3_midrst_r", 32'(if3.dcache_r), 32'd0);
        check("w3_midrst_acc", acc_cnt3, 32'd0);
        check("w3_midrst_stall", stall_cnt3, 32'd0);
        if3.dcache_en = 1'b0;
        @(negedge clk);
        rst3 = 1'b0;
        exp_acc3 = 0;
        exp_stall3 = 0;
        @(posedge clk); #1;
        acc3(16'h0012, 2'b00, 16'h0000, 16'hABCD, "w3_post_rst");
        check("w3_post_rst_acc", acc_cnt3, 32'd1);
        check("w3_post_rst_stall", stall_cnt3, 32'd3);

        @(posedge clk); #1;
        check("sb0_drained", 32'(q0.size()), 32'd0);
        check("sb3_drained", 32'(q3.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lc3bp_dmem_wait_model.md
Name: lc3bp_dmem_wait_model

Overview:
Parametrised, synthesizable data-memory model for the LC3BP D-cache port. It replaces the always-ready DMEM used in full-system benches. Adds programmable wait states, per-byte-lane write enables for any DATA_W, request capture, abort handling and access/stall statistics. Sits between LC3BP_TOP_FULL's dcache_* port and the bench; backdoor preload is done hierarchically on the storage array `mem`.

Parameters:
DATA_W, 16, data word width; multiple of 8; LANES = DATA_W/8.
ADDR_W, 16, byte-address width.
DEPTH_WORDS, 32768, storage depth in words; power of 2.
WAIT_CYCLES, 0, fixed wait states per access, range 0..15.
CNT_W, 32, width of the statistics counters.

Ports:
clk  in  1  single clock; all state on posedge.
rst  in  1  asynchronous, active-high reset.
dcache_en  in  1  request valid; held by the core until dcache_r.
dcache_we  in  LANES  per-lane write enable; all-zero = read.
dcache_addr  in  ADDR_W  byte address.
dcache_din  in  DATA_W  write data.
dcache_r  out  1  ready/ack: access completes in this cycle.
dcache_dout  out  DATA_W  read data, valid while dcache_r=1 for a read.
access_cnt  out  CNT_W  completed accesses.
stall_cnt  out  CNT_W  cycles with dcache_en=1 and dcache_r=0.

Behaviour:
- Word index = (dcache_addr >> log2(LANES)) mod DEPTH_WORDS. Low address bits are ignored. No misalignment fault.
- Storage is not reset; contents are preserved across rst.
- Reset values: dcache_r=0, dcache_dout=0, access_cnt=0, stall_cnt=0, FSM=IDLE, wait counter=0. Reset mid-access aborts it with no write.
- WAIT_CYCLES=0 (combinational path):
  - dcache_r = dcache_en.
  - dcache_dout = mem[idx] when en=1, else 0.
  - Write of the enabled lanes commits at the posedge ending the en cycle.
  - Back-to-back accesses run every cycle.
- WAIT_CYCLES=N>0, FSM IDLE/WAIT/RESP:
  - IDLE: en=1 captures addr, we and din into registers, loads cnt=N-1 and goes to WAIT. If N=1, goes directly to RESP.
  - WAIT: cnt decrements each cycle; at cnt=0 goes to RESP.
  - RESP: dcache_r=1 for exactly one cycle. dcache_dout = mem[captured idx] for reads, 0 for writes. Captured write lanes commit at the posedge ending RESP. Returns to IDLE.
  - First ack is N cycles after the request cycle, so N stall cycles per access.
- Core-side changes to addr/we/din after capture are ignored.
- en dropping in WAIT or RESP: abort, return to IDLE next cycle, no write, no count; dcache_r forced 0 that cycle.
- After RESP, en still high in IDLE is a new request (recaptured).
- dcache_dout is 0 whenever dcache_r=0.
- access_cnt increments on each cycle with dcache_r=1.
- stall_cnt increments on each en=1 && dcache_r=0 cycle. Both counters saturate at all-ones.

Optional Feature:
DMEM_RAND_WAIT_EN:
- Defined: per-request wait = LFSR value mod (WAIT_CYCLES+1), sampled at capture. A sample of 0 goes IDLE->RESP, giving a 1-cycle ack; the 0-latency combinational path is never used. LFSR is 16-bit, x^16+x^14+x^13+x^11, seeded 16'hACE1 on rst, and steps once per capture.
- Undefined: fixed WAIT_CYCLES as above; no LFSR logic present.

Decomposition:
- Package lc3bp_mem_pkg: FSM state enum (IDLE/WAIT/RESP), LFSR seed and tap constants, lane-width constant 8, counter-saturate helper function.
- One sub-module, lc3bp_lfsr16 (clk, rst, step, value[15:0]), instantiated only under DMEM_RAND_WAIT_EN.

Test Plan:
- WAIT_CYCLES=0: write 0x0005 to 0x0000 (we=11), then read 0x0000 -> dcache_r same cycle, dout=0x0005, access_cnt=2, stall_cnt=0.
- WAIT_CYCLES=3: read 0x0010 preloaded 0xBEEF -> r=0 for 3 cycles, r=1 on cycle 3 with dout=0xBEEF; stall_cnt=3. Changing addr during WAIT has no effect.
- Byte lanes: mem[0]=0x1234; write din=0xABCD we=01 -> 0x12CD; then we=10 -> 0xABCD.
- Abort: WAIT_CYCLES=4, write request; drop en after 2 cycles -> no write, access_cnt unchanged, FSM IDLE next cycle.
- Reset mid-WAIT: assert rst async -> dcache_r=0 and counters 0 immediately. Memory retains prior contents; next request latency is N again.
- DMEM_RAND_WAIT_EN, WAIT_CYCLES=7: 100 reads -> every ack latency in 1..7 cycles, data correct, stall_cnt equals the sum of the per-request waits.
